// File: rtl/mux16_bus_arbiter_if.sv
// Handshake bundle between four requesters, the shared-bus arbiter and the single sink.
// The master modport is the arbiter's view; slave is the requester/sink side.
interface mux16_bus_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_src;
    logic               out_ready;

    modport master (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src
    );

    modport slave (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src
    );
endinterface

// File: rtl/mux16_bus_arbiter.sv
// Four-way shared-bus arbiter with bursts of up to MAX_BURST beats per grant.
// MUX16_ARB_ROUND_ROBIN_EN selects round-robin from last+1; otherwise fixed priority (0 highest).
module mux16_bus_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    mux16_bus_arbiter_if.master bus
);
    localparam int unsigned   CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic [1:0]       r_last;
    logic [1:0]       w_last_nxt;
    logic [CW-1:0]    r_beat;
    logic [CW-1:0]    w_beat_nxt;
    logic [1:0]       w_winner;
    logic             w_any_req;
    logic             w_owner_valid;
    logic [WIDTH-1:0] w_sel_data;

    assign w_any_req     = |bus.req_valid;
    assign w_owner_valid = bus.req_valid[r_owner];
    assign bus.out_src   = r_owner;

`ifdef MUX16_ARB_ROUND_ROBIN_EN
    // Nearest valid requester after the previous owner, wrapping; last itself is lowest.
    always_comb begin
        logic found;
        logic [1:0] idx;
        found    = 1'b0;
        w_winner = r_last + 2'd1;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!found && bus.req_valid[idx]) begin
                w_winner = idx;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_winner = 2'd0;
        if (bus.req_valid[0])      w_winner = 2'd0;
        else if (bus.req_valid[1]) w_winner = 2'd1;
        else if (bus.req_valid[2]) w_winner = 2'd2;
        else if (bus.req_valid[3]) w_winner = 2'd3;
    end
`endif

    always_comb begin
        case (r_owner)
            2'd0:    w_sel_data = bus.req_data[0*WIDTH +: WIDTH];
            2'd1:    w_sel_data = bus.req_data[1*WIDTH +: WIDTH];
            2'd2:    w_sel_data = bus.req_data[2*WIDTH +: WIDTH];
            default: w_sel_data = bus.req_data[3*WIDTH +: WIDTH];
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_beat_nxt    = r_beat;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = w_winner;
                    w_beat_nxt  = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                bus.out_valid          = w_owner_valid;
                bus.req_ready[r_owner] = bus.out_ready;
                if (w_owner_valid) begin
                    bus.out_data = w_sel_data;
                end
                // An owner that drops valid gives up the rest of its burst immediately.
                if (!w_owner_valid) begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = IDLE;
                end else if (bus.out_ready) begin
                    if (r_beat == LAST_BEAT) begin
                        w_beat_nxt  = '0;
                        w_last_nxt  = r_owner;
                        w_state_nxt = IDLE;
                    end else begin
                        w_beat_nxt = r_beat + CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_last  <= 2'd3;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
        end
    end
endmodule
